mul_issue: RTL and testbench
============================

# mul_issue

Issue/complete controller between the execute stage and the iterative multiplier core of the CPU. It latches one multiply op (mul.w, mulh.w, mulh.wu) from EX and holds its operands stable for the whole core computation. It sequences the core's in_valid/out_valid handshake and applies the signed high-word correction, because the core multiplies unsigned. It presents one registered 32-bit result to the writeback path and asserts a pipeline stall until that result is consumed.

## Interface
- No parameters; widths fixed at 32.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ex_valid  in  1  EX presents a multiply op this cycle
- ex_op  in  2  00 mul.w (low word), 01 mulh.w (signed high), 10 mulh.wu (unsigned high), 11 reserved, treated as 00
- src_a, src_b  in  32  operands
- flush  in  1  kill any in-flight op
- wb_allowin  in  1  downstream accepts the result this cycle
- res_valid  out  1  res_data holds a completed result
- res_data  out  32  result word
- stallreq  out  1  freeze EX/ID
- core_in_valid  out  1  to multiplier in_valid
- core_a, core_b  out  32  to multiplier a/b, registered
- core_out_valid  in  1  from multiplier out_valid (high when core counter is zero)
- core_result_h, core_result_l  in  32  multiplier product words

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - Accept when ex_valid & core_out_valid & ~flush.
  - On accept: register op, core_a=src_a, core_b=src_b; go to ISSUE.
  - If core_out_valid=0 (core still draining a flushed op), do not accept; stallreq stays high while ex_valid.
- ISSUE: core_in_valid=1 for exactly this cycle; go to WAIT.
- WAIT:
  - Ignore core_out_valid in the first WAIT cycle, while the core counter is nonzero.
  - On the first core_out_valid=1 after that, compute the result and register it into res_data; go to DONE.
- DONE:
  - res_valid=1.
  - If wb_allowin=1, go to IDLE; the same cycle may accept a new op only in the following IDLE cycle, with no bypass.
  - If wb_allowin=0, hold res_data/res_valid unchanged.
- Result select:
  - mul.w: core_result_l.
  - mulh.wu: core_result_h.
  - mulh.w: core_result_h − (a[31] ? b : 0) − (b[31] ? a : 0), modulo 2^32.
- core_a/core_b are held unchanged from accept until the next accept.
- stallreq = (IDLE & ex_valid) | ISSUE | WAIT | (DONE & ~wb_allowin); forced 0 while reset=1.
- flush:
  - In any state, next state is IDLE and res_valid=0 next cycle.
  - The result of a flushed op is discarded.
  - flush together with ex_valid in IDLE: flush wins, no accept.
  - The core is not reset by flush; the drain is handled by the IDLE core_out_valid gate.
- reset (including mid-operation): state=IDLE, res_valid=0, res_data=0, core_in_valid=0, core_a=core_b=0 on the next edge.

## Timing
- Cycle 0: accept (IDLE, ex_valid).
- Cycle 1: ISSUE, core_in_valid=1.
- Cycle 2: WAIT, core busy.
- Cycle 3: WAIT, core_out_valid=1, result captured.
- Cycle 4: DONE, res_valid=1.
- Latency from accept to res_valid is 4 cycles. Back-to-back throughput is one op per 5 cycles when wb_allowin=1.
- stallreq is high from cycle 0 through cycle 3, and in cycle 4 only if wb_allowin=0.
- Outputs res_valid, res_data, core_* are registered. stallreq is combinational from ex_valid, wb_allowin and state.

## Structure
- Shared package (mycpu defines header): MUL_OP_W/MUL_OP_H/MUL_OP_HU encodings and FSM state encodings, 2 bits each.
- One natural sub-module: mulh_fix, a combinational signed high-word correction taking a, b, hi and returning the corrected hi. Unit-testable on its own.
- Controller FSM plus registers stay in mul_issue, about 150–200 lines.

## Test plan
- mul.w 3×5, wb_allowin=1 → res_valid at cycle 4, res_data=0x0000000F, stallreq high cycles 0–3.
- mulh.w 0xFFFFFFFF×0xFFFFFFFF → res_data=0x00000000; mulh.w 0x80000000×0x00000002 → 0xFFFFFFFF.
- mulh.wu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; mul.w same operands → 0x00000001.
- Backpressure: wb_allowin=0 for 3 cycles in DONE → res_data stable, stallreq high; it drops the cycle wb_allowin=1 and state returns to IDLE.
- flush asserted in ISSUE:
  - res_valid is never asserted for that op.
  - A new ex_valid presented immediately waits until core_out_valid=1, then completes with the correct value.
- reset asserted in WAIT → next cycle all outputs zero and state IDLE. Reset and flush together with ex_valid → no accept.

Source files
------------

// File: rtl/mul_issue_pkg.sv
// mul_issue_pkg: shared op and FSM state encodings for the multiply issue controller
package mul_issue_pkg;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {
        MUL_OP_W   = 2'b00,
        MUL_OP_H   = 2'b01,
        MUL_OP_HU  = 2'b10,
        MUL_OP_RSV = 2'b11
    } mul_op_t;
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_DONE  = 2'b11
    } state_t;
endpackage

// File: rtl/mul_issue_if.sv
// mul_issue_if: EX, writeback and multiplier-core signals of the multiply issue controller
interface mul_issue_if;
    import mul_issue_pkg::*;
    logic            ex_valid;
    logic [1:0]      ex_op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            wb_allowin;
    logic            res_valid;
    logic [XLEN-1:0] res_data;
    logic            stallreq;
    logic            core_in_valid;
    logic [XLEN-1:0] core_a;
    logic [XLEN-1:0] core_b;
    logic            core_out_valid;
    logic [XLEN-1:0] core_result_h;
    logic [XLEN-1:0] core_result_l;
    modport slave (
        input  ex_valid, ex_op, src_a, src_b, flush, wb_allowin,
        input  core_out_valid, core_result_h, core_result_l,
        output res_valid, res_data, stallreq, core_in_valid, core_a, core_b
    );
    modport master (
        output ex_valid, ex_op, src_a, src_b, flush, wb_allowin,
        output core_out_valid, core_result_h, core_result_l,
        input  res_valid, res_data, stallreq, core_in_valid, core_a, core_b
    );
endinterface

// File: rtl/mul_issue_mulh_fix.sv
// mulh_fix: turns the unsigned high product word into the signed high word
module mulh_fix
    import mul_issue_pkg::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [XLEN-1:0] i_hi,
    output logic [XLEN-1:0] o_hi
);
    assign o_hi = i_hi - (i_a[XLEN-1] ? i_b : '0) - (i_b[XLEN-1] ? i_a : '0);
endmodule

// File: rtl/mul_issue.sv
// mul_issue: issues one multiply to the iterative core, holds operands, registers and presents the result
module mul_issue
    import mul_issue_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mul_issue_if.slave bus
);
    state_t          r_state;
    state_t          w_next;
    mul_op_t         r_op;
    logic [XLEN-1:0] r_core_a;
    logic [XLEN-1:0] r_core_b;
    logic [XLEN-1:0] r_res_data;
    logic            r_res_valid;
    logic            r_core_in_valid;
    logic            r_wait_first;
    logic            w_accept;
    logic            w_capture;
    logic [XLEN-1:0] w_hi_fix;
    logic [XLEN-1:0] w_result;

    mulh_fix u_fix (
        .i_a  (r_core_a),
        .i_b  (r_core_b),
        .i_hi (bus.core_result_h),
        .o_hi (w_hi_fix)
    );

    // next state; flush overrides every transition and suppresses accept/capture
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: if (bus.ex_valid && bus.core_out_valid) begin
                w_accept = 1'b1;
                w_next   = S_ISSUE;
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: if (!r_wait_first && bus.core_out_valid) begin
                w_capture = 1'b1;
                w_next    = S_DONE;
            end
            S_DONE: if (bus.wb_allowin) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.flush) begin
            w_next    = S_IDLE;
            w_accept  = 1'b0;
            w_capture = 1'b0;
        end
    end

    // result word selection by latched op
    always_comb begin
        w_result = r_op == MUL_OP_H  ? w_hi_fix :
                   r_op == MUL_OP_HU ? bus.core_result_h : bus.core_result_l;
    end

    // state register; first WAIT cycle is flagged because the core still shows its stale out_valid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wait_first <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_wait_first <= r_state == S_ISSUE;
        end
    end

    // operand latch, core handshake and registered result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op            <= MUL_OP_W;
            r_core_a        <= '0;
            r_core_b        <= '0;
            r_core_in_valid <= 1'b0;
            r_res_valid     <= 1'b0;
            r_res_data      <= '0;
        end else begin
            r_core_in_valid <= w_accept;
            r_res_valid     <= w_next == S_DONE;
            if (w_accept) begin
                r_op     <= bus.ex_op == MUL_OP_RSV ? MUL_OP_W : mul_op_t'(bus.ex_op);
                r_core_a <= bus.src_a;
                r_core_b <= bus.src_b;
            end
            if (w_capture) r_res_data <= w_result;
        end
    end

    assign bus.stallreq      = !reset && ((r_state == S_IDLE && bus.ex_valid) ||
                                          r_state == S_ISSUE || r_state == S_WAIT ||
                                          (r_state == S_DONE && !bus.wb_allowin));
    assign bus.res_valid     = r_res_valid;
    assign bus.res_data      = r_res_data;
    assign bus.core_in_valid = r_core_in_valid;
    assign bus.core_a        = r_core_a;
    assign bus.core_b        = r_core_b;
endmodule

// File: tb/tb_mul_issue.sv
// tb_mul_issue: directed tests of mul_issue against a behavioural model and a latency-configurable core model
module tb_mul_issue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic chk_en = 1'b0;
    int   core_lat = 1;

    mul_issue_if bus();

    mul_issue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // multiplier core: unsigned product, busy for core_lat cycles after in_valid
    logic [7:0]  c_cnt = 8'd0;
    logic [63:0] c_prod = 64'd0;
    always @(posedge clk) begin
        if (reset) begin
            c_cnt  <= 8'd0;
            c_prod <= 64'd0;
        end else if (bus.core_in_valid) begin
            c_cnt  <= core_lat[7:0];
            c_prod <= {32'd0, bus.core_a} * {32'd0, bus.core_b};
        end else if (c_cnt != 8'd0) begin
            c_cnt <= c_cnt - 8'd1;
        end
    end
    assign bus.core_out_valid = c_cnt == 8'd0;
    assign bus.core_result_h  = c_prod[63:32];
    assign bus.core_result_l  = c_prod[31:0];

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
        logic [63:0] up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        sp = sa * sb;
        up = {32'd0, a} * {32'd0, b};
        return op == 2'b01 ? sp[63:32] : op == 2'b10 ? up[63:32] : up[31:0];
    endfunction

    // model: 0 idle, 1 issue, 2 first wait, 3 wait for core, 4 result held
    int          m_stage = 0;
    logic [31:0] m_exp = 32'd0;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_b = 32'd0;
    always @(posedge clk) begin
        if (reset) begin
            m_stage <= 0;
            m_a     <= 32'd0;
            m_b     <= 32'd0;
        end else if (bus.flush) begin
            m_stage <= 0;
        end else if (m_stage == 0) begin
            if (bus.ex_valid && bus.core_out_valid) begin
                m_stage <= 1;
                m_a     <= bus.src_a;
                m_b     <= bus.src_b;
                m_exp   <= ref_mul(bus.ex_op, bus.src_a, bus.src_b);
            end
        end else if (m_stage == 1 || m_stage == 2) begin
            m_stage <= m_stage + 1;
        end else if (m_stage == 3) begin
            if (bus.core_out_valid) m_stage <= 4;
        end else if (bus.wb_allowin) begin
            m_stage <= 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            logic e_stall;
            e_stall = !reset && ((m_stage == 0 && bus.ex_valid) || (m_stage >= 1 && m_stage <= 3) ||
                                 (m_stage == 4 && !bus.wb_allowin));
            chk("cmp_res_valid", {31'd0, bus.res_valid}, {31'd0, m_stage == 4});
            if (m_stage == 4) chk("cmp_res_data", bus.res_data, m_exp);
            chk("cmp_stallreq", {31'd0, bus.stallreq}, {31'd0, e_stall});
            chk("cmp_core_in_valid", {31'd0, bus.core_in_valid}, {31'd0, m_stage == 1});
            chk("cmp_core_a", bus.core_a, m_a);
            chk("cmp_core_b", bus.core_b, m_b);
        end
    end

    // present an op (caller sits just after a posedge); returns at the negedge of the first res_valid cycle
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int stalls, output logic [31:0] data);
        int   t0;
        logic seen;
        logic drop;
        bus.ex_valid = 1'b1;
        bus.ex_op    = op;
        bus.src_a    = a;
        bus.src_b    = b;
        t0 = cyc;
        stalls = 0;
        seen = 1'b0;
        drop = 1'b0;
        lat = -1;
        data = 32'hDEAD_BEEF;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                seen = 1'b1;
                lat  = cyc - t0;
                data = bus.res_data;
            end else begin
                if (bus.stallreq) stalls++;
                if (bus.core_in_valid) drop = 1'b1;
                @(posedge clk);
                #1;
                if (drop) bus.ex_valid = 1'b0;
            end
        end
        bus.ex_valid = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL run_op_timeout: got no res_valid want res_valid within 60 cycles");
        end
    endtask

    logic [1:0]  t_op [9] = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1, 2'd3, 2'd2, 2'd1};
    logic [31:0] t_a  [9] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,
                              32'h7FFFFFFF, 32'h00000007, 32'h80000000, 32'h80000000};
    logic [31:0] t_b  [9] = '{32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000003,
                              32'h7FFFFFFF, 32'h00000006, 32'h80000000, 32'h80000000};
    logic [31:0] t_r  [9] = '{32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF,
                              32'h3FFFFFFF, 32'h0000002A, 32'h40000000, 32'h40000000};

    initial begin
        int          lat;
        int          stalls;
        logic [31:0] data;
        bus.ex_valid   = 1'b0;
        bus.ex_op      = 2'd0;
        bus.src_a      = 32'd0;
        bus.src_b      = 32'd0;
        bus.flush      = 1'b0;
        bus.wb_allowin = 1'b1;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_res_data", bus.res_data, 32'd0);
        chk("rst_core_in_valid", {31'd0, bus.core_in_valid}, 32'd0);
        chk("rst_stallreq", {31'd0, bus.stallreq}, 32'd0);

        @(posedge clk);
        #1 run_op(2'd0, 32'd3, 32'd5, lat, stalls, data);
        chk("mulw_3x5_data", data, 32'h0000000F);
        chk("mulw_3x5_latency", lat, 32'd4);
        chk("mulw_3x5_stall_cycles", stalls, 32'd4);

        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1 run_op(t_op[i], t_a[i], t_b[i], lat, stalls, data);
            chk($sformatf("table%0d_data", i), data, t_r[i]);
            chk($sformatf("table%0d_latency", i), lat, 32'd4);
        end

        @(posedge clk);
        #1 bus.wb_allowin = 1'b0;
        run_op(2'd0, 32'h1234, 32'h10, lat, stalls, data);
        chk("bp_data", data, 32'h00012340);
        chk("bp_stall0", {31'd0, bus.stallreq}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_data", bus.res_data, 32'h00012340);
            chk("bp_hold_stall", {31'd0, bus.stallreq}, 32'd1);
        end
        @(posedge clk);
        #1 bus.wb_allowin = 1'b1;
        @(negedge clk);
        chk("bp_release_stall", {31'd0, bus.stallreq}, 32'd0);
        chk("bp_release_valid", {31'd0, bus.res_valid}, 32'd1);
        @(negedge clk);
        chk("bp_after_valid", {31'd0, bus.res_valid}, 32'd0);

        @(posedge clk);
        #1 core_lat = 6;
        bus.ex_valid = 1'b1;
        bus.ex_op    = 2'd0;
        bus.src_a    = 32'h10;
        bus.src_b    = 32'h10;
        @(posedge clk);
        #1 bus.ex_valid = 1'b0;
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        core_lat = 1;
        run_op(2'd0, 32'h00010001, 32'h00010001, lat, stalls, data);
        chk("flush_new_data", data, 32'h00020001);
        chk("flush_new_latency", lat, 32'd10);

        @(posedge clk);
        #1 bus.ex_valid = 1'b1;
        bus.ex_op = 2'd2;
        bus.src_a = 32'd5;
        bus.src_b = 32'd7;
        @(posedge clk);
        #1 bus.ex_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_wait_stall", {31'd0, bus.stallreq}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_wait_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_wait_res_data", bus.res_data, 32'd0);
        chk("rst_wait_core_in_valid", {31'd0, bus.core_in_valid}, 32'd0);
        chk("rst_wait_core_a", bus.core_a, 32'd0);
        chk("rst_wait_core_b", bus.core_b, 32'd0);
        chk("rst_wait_stall_after", {31'd0, bus.stallreq}, 32'd0);

        @(posedge clk);
        #1 reset = 1'b1;
        bus.flush    = 1'b1;
        bus.ex_valid = 1'b1;
        bus.src_a    = 32'd9;
        bus.src_b    = 32'd9;
        @(posedge clk);
        #1 reset = 1'b0;
        bus.flush    = 1'b0;
        bus.ex_valid = 1'b0;
        @(negedge clk);
        chk("rst_flush_no_accept", {31'd0, bus.core_in_valid}, 32'd0);
        chk("rst_flush_core_a", bus.core_a, 32'd0);

        @(posedge clk);
        #1 bus.flush = 1'b1;
        bus.ex_valid = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        bus.ex_valid = 1'b0;
        @(negedge clk);
        chk("flush_idle_no_accept", {31'd0, bus.core_in_valid}, 32'd0);
        chk("flush_idle_core_a", bus.core_a, 32'd0);

        @(posedge clk);
        #1 run_op(2'd1, 32'hFFFFFFFE, 32'd3, lat, stalls, data);
        chk("recover_data", data, 32'hFFFFFFFF);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
